// File: rtl/mopa_tile_unit.sv
// Matrix execute unit: one 4x4 tile of 32-bit accumulators, running MOPA / MVTR / MVTM beside the EX-stage ALU.
// Optional feature macro: MOPA_SATURATE_EN (signed-saturating accumulate; wrap-around modulo 2^32 when undefined).
module mopa_tile_unit (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid_i,
    input  logic [2:0]  func3_i,
    input  logic [3:0]  alu_ctrl_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rd_data_o
);

    // Sub-op and ALU control codes, matching define.vh
    localparam logic [2:0] M_MVTR   = 3'd2;
    localparam logic [2:0] M_MVTM   = 3'd3;
    localparam logic [2:0] M_MOPA   = 3'd4;
    localparam logic [3:0] ALU_MOPA = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  row_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] tile_r [16];
    logic        ready_r;
    logic        done_r;
    logic        err_r;
    logic [31:0] rd_r;

    logic        accept_s;
    logic        mopa_ok_s;
    logic        mopa_bad_s;
    logic        mvtr_s;
    logic        mvtm_s;
    logic [3:0]  idx_s;

    // One multiply-accumulate step: signed 8x8 product, sign-extended, added to the accumulator
    function automatic logic [31:0] mac_f(input logic [31:0] acc, input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic signed [15:0] prod;
        logic        [31:0] ext;
`ifdef MOPA_SATURATE_EN
        logic        [32:0] sum;
`endif
        sa   = {{8{a[7]}}, a};
        sb   = {{8{b[7]}}, b};
        prod = sa * sb;
        ext  = {{16{prod[15]}}, prod};
`ifdef MOPA_SATURATE_EN
        sum = {acc[31], acc} + {ext[31], ext};
        if (sum[32] != sum[31]) begin
            mac_f = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            mac_f = sum[31:0];
        end
`else
        mac_f = acc + ext;
`endif
    endfunction

    // Instruction decode; ready_r is low whenever the unit is busy, so busy-time requests drop here
    always_comb begin
        idx_s      = src_a_i[3:0];
        accept_s   = valid_i & ready_r &
                     ((func3_i == M_MOPA) | (func3_i == M_MVTR) | (func3_i == M_MVTM));
        mopa_ok_s  = accept_s & (func3_i == M_MOPA) & (alu_ctrl_i == ALU_MOPA);
        mopa_bad_s = accept_s & (func3_i == M_MOPA) & (alu_ctrl_i != ALU_MOPA);
        mvtr_s     = accept_s & (func3_i == M_MVTR);
        mvtm_s     = accept_s & (func3_i == M_MVTM);
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mopa_ok_s) begin
                    state_s = ST_ACC;
                end else if (accept_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (row_r == 2'd3) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ACC;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, row counter and operand latches
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            row_r   <= 2'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
        end else begin
            state_r <= state_s;
            if (state_r == ST_ACC) begin
                row_r <= row_r + 2'd1;
            end else begin
                row_r <= 2'd0;
            end
            if (accept_s) begin
                a_r <= src_a_i;
                b_r <= src_b_i;
            end
        end
    end

    // Registered handshake and result outputs, derived from the next state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            rd_r    <= 32'd0;
        end else begin
            ready_r <= (state_s == ST_IDLE);
            done_r  <= (state_s == ST_DONE);
            err_r   <= mopa_bad_s;
            if (mvtr_s) begin
                rd_r <= tile_r[idx_s];
            end
        end
    end

    // Tile storage: MVTM writes at accept, MOPA updates one row per ACC cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++) begin
                tile_r[i] <= 32'd0;
            end
        end else begin
            if (mvtm_s) begin
                tile_r[idx_s] <= src_b_i;
            end else if (state_r == ST_ACC) begin
                for (int j = 0; j < 4; j++) begin
                    tile_r[{row_r, 2'(j)}] <= mac_f(tile_r[{row_r, 2'(j)}],
                                                    a_r[{row_r, 3'b000} +: 8],
                                                    b_r[{2'(j), 3'b000} +: 8]);
                end
            end
        end
    end

    assign ready_o   = ready_r;
    assign done_o    = done_r;
    assign err_o     = err_r;
    assign rd_data_o = rd_r;

endmodule

// File: tb/tb_mopa_tile_unit.sv
// Self-checking bench for mopa_tile_unit: directed table, multi-cycle corner sequences, randomized ops vs a tile model.
module tb_mopa_tile_unit;

    localparam logic [2:0] M_LD     = 3'd0;
    localparam logic [2:0] M_MVTR   = 3'd2;
    localparam logic [2:0] M_MVTM   = 3'd3;
    localparam logic [2:0] M_MOPA   = 3'd4;
    localparam logic [3:0] ALU_MOPA = 4'b1100;
    localparam logic [3:0] ALU_ADD  = 4'b0010;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid_i;
    logic [2:0]  func3_i;
    logic [3:0]  alu_ctrl_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic        ready_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rd_data_o;

    int          n_vec = 0;
    int          n_bad = 0;
    int          model [16];
    logic [31:0] last_rd;

    mopa_tile_unit dut (
        .clk        (clk),
        .rstn       (rstn),
        .valid_i    (valid_i),
        .func3_i    (func3_i),
        .alu_ctrl_i (alu_ctrl_i),
        .src_a_i    (src_a_i),
        .src_b_i    (src_b_i),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .rd_data_o  (rd_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic [31:0] a;
        logic [31:0] b;
        logic        chk;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: C[r][j] += a[r]*b[j] with plain integer arithmetic
    function automatic void model_mopa(input logic [31:0] a, input logic [31:0] b);
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                int     p;
                longint s;
                p = int'($signed(a[8*r +: 8])) * int'($signed(b[8*j +: 8]));
                s = longint'(model[r*4+j]) + longint'(p);
`ifdef MOPA_SATURATE_EN
                if (s > 64'sd2147483647) s = 64'sd2147483647;
                if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
                model[r*4+j] = int'(s);
            end
        end
    endfunction

    // Issue one instruction, check latency/err/ready, update the model, return rd_data_o at done
    task automatic run_op(input logic [2:0] f3, input logic [3:0] alu, input logic [31:0] a,
                          input logic [31:0] b, input string tag, output logic [31:0] rd);
        logic legal;
        logic exp_err;
        int   exp_lat;
        int   lat;
        legal   = (f3 == M_MOPA) && (alu == ALU_MOPA);
        exp_err = (f3 == M_MOPA) && !legal;
        exp_lat = legal ? 5 : 1;
        check({tag, " ready_before"}, 32'(ready_o), 32'd1);
        func3_i = f3; alu_ctrl_i = alu; src_a_i = a; src_b_i = b; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 1;
        while (done_o !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " err"}, 32'(err_o), 32'(exp_err));
        check({tag, " ready_at_done"}, 32'(ready_o), 32'd0);
        rd = rd_data_o;
        if (legal) model_mopa(a, b);
        if (f3 == M_MVTM) model[a[3:0]] = int'(b);
        @(posedge clk); #1;
        check({tag, " ready_after"}, 32'(ready_o), 32'd1);
        check({tag, " done_after"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] exp;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  alu;
        int          k;

        rstn = 1'b0; valid_i = 1'b0; func3_i = 3'd0; alu_ctrl_i = 4'd0;
        src_a_i = 32'd0; src_b_i = 32'd0; last_rd = 32'd0;
        for (int i = 0; i < 16; i++) model[i] = 0;

        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 32'(ready_o), 32'd1);
        check("reset done", 32'(done_o), 32'd0);
        check("reset err", 32'(err_o), 32'd0);
        check("reset rd", rd_data_o, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        tbl[0]  = '{M_MVTR, ALU_MOPA, 32'd5,          32'd0,          1'b1, 32'h0000_0000};
        tbl[1]  = '{M_MOPA, ALU_MOPA, 32'h0403_0201,  32'hFF02_0301,  1'b0, 32'h0};
        tbl[2]  = '{M_MVTR, ALU_MOPA, 32'd15,         32'd0,          1'b1, 32'hFFFF_FFFC};
        tbl[3]  = '{M_MVTR, ALU_MOPA, 32'd5,          32'd0,          1'b1, 32'h0000_0006};
        tbl[4]  = '{M_MVTR, ALU_MOPA, 32'd10,         32'd0,          1'b1, 32'h0000_0006};
        tbl[5]  = '{M_MVTR, ALU_MOPA, 32'd3,          32'd0,          1'b1, 32'hFFFF_FFFF};
        tbl[6]  = '{M_MOPA, ALU_ADD,  32'h7F7F_7F7F,  32'h7F7F_7F7F,  1'b0, 32'h0};
        tbl[7]  = '{M_MVTR, ALU_MOPA, 32'd15,         32'd0,          1'b1, 32'hFFFF_FFFC};
        tbl[8]  = '{M_MVTM, ALU_MOPA, 32'd0,          32'h7FFF_FFFF,  1'b0, 32'h0};
        tbl[9]  = '{M_MOPA, ALU_MOPA, 32'h0000_0001,  32'h0000_0001,  1'b0, 32'h0};
`ifdef MOPA_SATURATE_EN
        tbl[10] = '{M_MVTR, ALU_MOPA, 32'd0,          32'd0,          1'b1, 32'h7FFF_FFFF};
`else
        tbl[10] = '{M_MVTR, ALU_MOPA, 32'd0,          32'd0,          1'b1, 32'h8000_0000};
`endif
        tbl[11] = '{M_MVTR, ALU_MOPA, 32'hFFFF_FFF1,  32'd0,          1'b1, 32'h0000_0003};

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].f3, tbl[i].alu, tbl[i].a, tbl[i].b, $sformatf("tbl%0d", i), rd);
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d rd", i), rd, tbl[i].exp_rd);
                last_rd = rd;
            end
        end

        // M_LD is not a unit op: no done, ready stays high
        func3_i = M_LD; alu_ctrl_i = ALU_MOPA; src_a_i = 32'd1; valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("ld ready", 32'(ready_o), 32'd1);
            check("ld done", 32'(done_o), 32'd0);
        end
        valid_i = 1'b0;

        // MOPA followed by an MVTM held during the busy window must be dropped
        ra = $urandom; rb = $urandom;
        func3_i = M_MOPA; alu_ctrl_i = ALU_MOPA; src_a_i = ra; src_b_i = rb; valid_i = 1'b1;
        @(posedge clk); #1;
        func3_i = M_MVTM; src_a_i = 32'd6; src_b_i = 32'hDEAD_BEEF;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("hold ready T+%0d", c), 32'(ready_o), 32'd0);
            check($sformatf("hold done T+%0d", c), 32'(done_o), (c == 5) ? 32'd1 : 32'd0);
            if (c < 5) begin
                @(posedge clk); #1;
            end
        end
        valid_i = 1'b0;
        model_mopa(ra, rb);
        @(posedge clk); #1;
        check("hold ready after", 32'(ready_o), 32'd1);
        run_op(M_MVTR, ALU_MOPA, 32'd6, 32'd0, "hold mvtr", rd);
        check("hold tile6", rd, 32'(model[6]));
        last_rd = rd;

        // Randomized mix against the model
        for (int n = 0; n < 60; n++) begin
            k  = $urandom_range(0, 9);
            ra = $urandom;
            rb = $urandom;
            if (k <= 3) begin
                exp = 32'(model[ra[3:0]]);
                run_op(M_MVTR, ALU_MOPA, ra, rb, $sformatf("rnd%0d mvtr", n), rd);
                check($sformatf("rnd%0d mvtr rd", n), rd, exp);
                last_rd = rd;
            end else begin
                if (k <= 6) begin
                    if (k == 5) rb = 32'h7FFF_FF00;
                    if (k == 6) rb = 32'h8000_0050;
                    run_op(M_MVTM, ALU_MOPA, ra, rb, $sformatf("rnd%0d mvtm", n), rd);
                end else if (k <= 8) begin
                    run_op(M_MOPA, ALU_MOPA, ra, rb, $sformatf("rnd%0d mopa", n), rd);
                end else begin
                    alu = 4'($urandom);
                    if (alu == ALU_MOPA) alu = ALU_ADD;
                    run_op(M_MOPA, alu, ra, rb, $sformatf("rnd%0d bad", n), rd);
                end
                check($sformatf("rnd%0d rd held", n), rd, last_rd);
            end
        end

        for (int i = 0; i < 16; i++) begin
            run_op(M_MVTR, ALU_MOPA, 32'(i), 32'd0, $sformatf("sweep%0d", i), rd);
            check($sformatf("sweep%0d rd", i), rd, 32'(model[i]));
        end

        // Asynchronous reset in the middle of a MOPA
        func3_i = M_MOPA; alu_ctrl_i = ALU_MOPA; src_a_i = $urandom; src_b_i = $urandom; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("midrst ready", 32'(ready_o), 32'd1);
        check("midrst done", 32'(done_o), 32'd0);
        check("midrst rd", rd_data_o, 32'd0);
        @(posedge clk); #1;
        check("midrst done later", 32'(done_o), 32'd0);
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            run_op(M_MVTR, ALU_MOPA, ra, 32'd0, $sformatf("postrst%0d", i), rd);
            check($sformatf("postrst%0d rd", i), rd, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
